hazard_ctrl: RTL

- Pipeline interlock controller for the iDEA DSP48E1 pipeline.
- Holds a scoreboard of in-flight register writes from ex1 through writeback.
- Stalls the fetch/decode stages on RAW hazards, since the core has no forwarding.
- Injects bubbles into ex1 and sequences multi-cycle flushes when a branch resolves taken.

---
 rtl/hazard_ctrl_pkg.sv | 23 ++
 rtl/hazard_sb.sv | 55 +++++
 rtl/hazard_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the DSP48E1 pipeline interlock: register address width,
// controller state encodings and the state enum built on them.
`ifndef HAZARD_CTRL_DEFINES
`define HAZARD_CTRL_DEFINES
`define REG_ADDR_WIDTH 5
`define HZ_STATE_WIDTH 2
`define HZ_RUN   2'd0
`define HZ_STALL 2'd1
`define HZ_FLUSH 2'd2
`endif

package hazard_ctrl_pkg;

  localparam int unsigned REG_AW = `REG_ADDR_WIDTH;
  localparam int unsigned HZ_SW  = `HZ_STATE_WIDTH;

  typedef enum logic [HZ_SW-1:0] {
    ST_RUN   = `HZ_RUN,
    ST_STALL = `HZ_STALL,
    ST_FLUSH = `HZ_FLUSH
  } hz_state_e;

endpackage

// File: rtl/hazard_sb.sv
// Scoreboard of in-flight register writes from ex1 to writeback, with
// wrong-path kill of the younger entries and dual source-address compare.
module hazard_sb
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned SB_DEPTH = 6,
  parameter int unsigned BR_STAGE = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue,
  input  logic              kill,
  input  logic [REG_AW-1:0] addr_rd,
  input  logic [REG_AW-1:0] addr_rs,
  input  logic [REG_AW-1:0] addr_rt,
  output logic              match_rs,
  output logic              match_rt,
  output logic              busy
);

  logic [SB_DEPTH-1:0] sb_v;
  logic [REG_AW-1:0]   sb_rd [SB_DEPTH];

  // Valid bits: entries younger than the branch stage are dropped on a taken branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_v <= '0;
    end else begin
      sb_v[0] <= issue;
      for (int i = 1; i < int'(SB_DEPTH); i++) begin
        sb_v[i] <= (kill && (i <= int'(BR_STAGE))) ? 1'b0 : sb_v[i-1];
      end
    end
  end

  // Destination addresses are only meaningful alongside their valid bit.
  always_ff @(posedge clk) begin
    sb_rd[0] <= addr_rd;
    for (int i = 1; i < int'(SB_DEPTH); i++) begin
      sb_rd[i] <= sb_rd[i-1];
    end
  end

  always_comb begin
    match_rs = 1'b0;
    match_rt = 1'b0;
    for (int i = 0; i < int'(SB_DEPTH); i++) begin
      if (sb_v[i] && (sb_rd[i] == addr_rs)) match_rs = 1'b1;
      if (sb_v[i] && (sb_rd[i] == addr_rt)) match_rt = 1'b1;
    end
  end

  assign busy = |sb_v;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline interlock controller: stalls fetch/decode on RAW hazards and
// sequences multi-cycle flushes after a taken branch.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned SB_DEPTH  = 6,
  parameter int unsigned BR_STAGE  = 3,
  parameter int unsigned FLUSH_LEN = 2,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       id_valid_i,
  input  logic                       rs_en_i,
  input  logic                       rt_en_i,
  input  logic [`REG_ADDR_WIDTH-1:0] addr_rs_i,
  input  logic [`REG_ADDR_WIDTH-1:0] addr_rt_i,
  input  logic                       rd_we_i,
  input  logic [`REG_ADDR_WIDTH-1:0] addr_rd_i,
  input  logic                       branch_taken_i,
  input  logic                       cnt_clr_i,
  output logic                       stall_o,
  output logic                       bubble_o,
  output logic                       flush_o,
  output logic                       busy_o,
  output logic [CNT_W-1:0]           stall_cnt_o
);

  localparam int unsigned FC_W = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
  localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_LEN - 1);

  hz_state_e       state;
  logic [FC_W-1:0] flush_cnt;
  logic            match_rs;
  logic            match_rt;
  logic            hazard;
  logic            issue;

  hazard_sb #(
    .SB_DEPTH (SB_DEPTH),
    .BR_STAGE (BR_STAGE)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .issue    (issue),
    .kill     (branch_taken_i),
    .addr_rd  (addr_rd_i),
    .addr_rs  (addr_rs_i),
    .addr_rt  (addr_rt_i),
    .match_rs (match_rs),
    .match_rt (match_rt),
    .busy     (busy_o)
  );

  // Interlock outputs act in the same cycle the hazard or branch is seen.
  assign hazard   = id_valid_i & ((rs_en_i & match_rs) | (rt_en_i & match_rt));
  assign flush_o  = branch_taken_i | (state == ST_FLUSH);
  assign stall_o  = hazard & ~flush_o;
  assign bubble_o = stall_o | flush_o;
  assign issue    = id_valid_i & rd_we_i & ~stall_o & ~flush_o;

  // A taken branch always wins; a new one during FLUSH restarts the window.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      flush_cnt <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (branch_taken_i) begin
            state     <= ST_FLUSH;
            flush_cnt <= FC_LOAD;
          end else if (hazard) begin
            state <= ST_STALL;
          end
        end
        ST_STALL: begin
          if (branch_taken_i) begin
            state     <= ST_FLUSH;
            flush_cnt <= FC_LOAD;
          end else if (!hazard) begin
            state <= ST_RUN;
          end
        end
        ST_FLUSH: begin
          if (branch_taken_i) begin
            flush_cnt <= FC_LOAD;
          end else if (flush_cnt == '0) begin
            state <= ST_RUN;
          end else begin
            flush_cnt <= flush_cnt - FC_W'(1);
          end
        end
        default: begin
          state     <= ST_RUN;
          flush_cnt <= '0;
        end
      endcase
    end
  end

  // Saturating stall-cycle counter; clear beats increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_o <= '0;
    end else if (cnt_clr_i) begin
      stall_cnt_o <= '0;
    end else if (stall_o && (stall_cnt_o != '1)) begin
      stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
  end

endmodule
